roll_mem_loader: RTL
====================

Name: roll_mem_loader

Overview:
- Receiving end of the bit-stream load interface: the stimulus side streams 5-bit roll words on `data` while `write` is high.
- The block stores each word in an internal DEPTH-entry memory, tracks the number of words loaded, and flags when loading is complete.
- It then returns stored words one at a time, in order, on each `next` pulse, wrapping over the loaded region.
- Sits between the load stream and the roll datapath (random_num source) inside top.

Parameters:
DATA_W, 5, width of each stored word
DEPTH, 32, number of memory entries
ADDR_W, 5, pointer width; must equal clog2(DEPTH)

Ports:
clk  input  1  system clock; all sequential logic on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
write  input  1  load strobe; each cycle high stores one word
data  input  DATA_W  word to store while write=1
next  input  1  read request; a one-cycle pulse returns one word
rd_data  output  DATA_W  word returned for the last accepted next
rd_valid  output  1  one-cycle pulse, rd_data valid
rd_addr  output  ADDR_W  index rd_data was read from
count  output  ADDR_W+1  number of words stored, 0..DEPTH
load_done  output  1  high while in READY
full  output  1  high when count==DEPTH

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; wr_ptr=0; rd_ptr=0; count=0; rd_data=0; rd_valid=0; rd_addr=0; load_done=0; full=0. Memory contents are not cleared and are don't-care.
- States: IDLE, LOAD, READY.
- IDLE, write=1: store data at mem[0]; wr_ptr=1; count=1; go to LOAD.
- IDLE, write=0: next is ignored.
- LOAD, write=1 and count<DEPTH: store at mem[wr_ptr]; increment wr_ptr and count.
- LOAD, write=1 and count==DEPTH: word dropped; full stays 1; no wrap, so earlier words are never overwritten.
- LOAD, write=0: go to READY; rd_ptr=0; load_done=1 from the next cycle.
- LOAD, next=1: ignored, no rd_valid.
- READY, next=1 and write=0:
  - The next rising edge registers rd_data=mem[rd_ptr], rd_addr=rd_ptr, rd_valid=1 (latency 1 cycle).
  - rd_ptr advances to rd_ptr+1, or to 0 when rd_ptr==count-1 (wrap over the loaded region only).
- READY, next held high N cycles: N consecutive reads, one per cycle.
- READY, write=1 (reload): count=1; wr_ptr=1; store at mem[0]; rd_ptr=0; load_done=0; go to LOAD. A next pulse in the same cycle is dropped (write has priority).
- rd_valid is 0 in every cycle without an accepted read. rd_data and rd_addr hold their last values between reads.
- full = (count==DEPTH), registered together with count.
- Reset asserted mid-LOAD or mid-READY: immediate return to IDLE with the reset values above. A partial load is discarded (count=0).
- Arithmetic:
  - count is ADDR_W+1 bits so DEPTH is representable.
  - Pointers are ADDR_W bits.
  - No signed arithmetic.

Test Plan:
- Reset load: reset=0 then 1; stream 31 words 0..30 with write=1, then drop write -> count=31, full=0, load_done=1 one cycle after write falls; mem[i]=i.
- Sequential read with wrap: after the load above, pulse next 33 times, spaced 3 cycles apart -> rd_data 0,1,…,30,0,1; rd_addr matches; exactly 33 rd_valid pulses, each 1 cycle after its next.
- Overflow: stream 40 words (values k mod 32) -> count=32, full=1; mem[31]=31; words 32..39 dropped; reads return 0..31 then 0.
- Back-to-back reads: load 4 words (7,3,9,1); hold next high 6 cycles -> rd_data 7,3,9,1,7,3 on consecutive cycles, rd_valid high 6 cycles.
- Reload priority: in READY, assert write and next in the same cycle with data=12 -> no rd_valid; state=LOAD; count=1; after write falls, the first read returns 12.
- Async reset mid-load: after 10 words, pull reset low mid-cycle -> count=0, load_done=0, rd_valid=0 immediately, without waiting for a clock edge; next afterwards is ignored until a new load.

Source files
------------

// File: rtl/roll_mem_loader.sv
// rtl/roll_mem_loader.sv - roll word store: stream-loaded memory replayed in order on next pulses
// Words are captured while write is high, then read back one per accepted next, wrapping over the loaded region.
module roll_mem_loader #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [DATA_W-1:0] data,
  input  logic              next,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              load_done,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_addr;
  logic [ADDR_W:0]   count_inc;
  logic              start_load, store_word, end_load, do_read, mem_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (write)  state_nxt = LOAD;
      LOAD:    if (!write) state_nxt = READY;
      READY:   if (write)  state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // A write outside LOAD always restarts the load at entry 0; write beats next.
  always_comb begin
    start_load = write && (state != LOAD);
    store_word = write && (state == LOAD) && (count != FULL_COUNT);
    end_load   = !write && (state == LOAD);
    do_read    = next && !write && (state == READY);
    load_done  = (state == READY);
  end

  assign count_inc = count + 1'b1;
  assign mem_we    = start_load || store_word;
  assign wr_addr   = start_load ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_read;
      if (start_load) begin
        wr_ptr <= ADDR_W'(1);
        count  <= (ADDR_W+1)'(1);
        full   <= ((ADDR_W+1)'(1) == FULL_COUNT);
        rd_ptr <= '0;
      end else if (store_word) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count_inc;
        full   <= (count_inc == FULL_COUNT);
      end
      if (end_load) rd_ptr <= '0;
      if (do_read) begin
        rd_data <= mem[rd_ptr];
        rd_addr <= rd_ptr;
        // Wrap at the last loaded word, not at the end of the memory.
        rd_ptr  <= ({1'b0, rd_ptr} == count - 1'b1) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

endmodule
